// File: rtl/io_bus_scheduler_pkg.sv
// Shared definitions for io_bus_scheduler: FSM state encoding and a
// constant-width helper.
package io_bus_scheduler_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE    = 2'd0,
    SCHED_GRANT   = 2'd1,
    SCHED_RELEASE = 2'd2
  } sched_state_e;

  // Returns the number of bits needed to index 'value' items (ceil(log2)).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/io_bus_scheduler_rr_pick.sv
// Combinational round-robin picker: returns the first set candidate at or
// after i_start, wrapping around the vector.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_cand,
  input  logic [IDW-1:0] i_start,
  output logic           o_valid,
  output logic [IDW-1:0] o_idx
);

  int w_pos;

  // Scan from the farthest offset down so the nearest candidate wins last.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = (int'(i_start) + k) % N;
      if (i_cand[w_pos]) begin
        o_valid = 1'b1;
        o_idx   = IDW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/io_bus_scheduler.sv
// Two-class round-robin scheduler for a shared I/O resource with hold limit.
// Optional starvation guard (age-based promotion) enabled by STARVATION_GUARD_EN.
module io_bus_scheduler
  import io_bus_scheduler_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_HOLD  = 16,
  parameter int AGE_LIMIT = 8,
  localparam int ID_W     = clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_prio,
  input  logic               i_done,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_id,
  output logic               o_busy,
  output logic               o_timeout
);

  localparam int HOLD_W = clog2(MAX_HOLD + 1);
  localparam int AGE_W  = clog2(AGE_LIMIT + 1);

  sched_state_e       r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [ID_W-1:0]    r_grant_id;
  logic               r_busy;
  logic               r_timeout;
  logic [ID_W-1:0]    r_ptr_p, r_ptr_n;
  logic [HOLD_W-1:0]  r_hold;

  logic [NUM_REQ-1:0] w_eff_prio;
  logic [NUM_REQ-1:0] w_cand_p, w_cand_n;
  logic               w_vld_p, w_vld_n;
  logic [ID_W-1:0]    w_idx_p, w_idx_n;
  logic               w_win_vld;
  logic [ID_W-1:0]    w_win_idx;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic               w_arb;
  logic [HOLD_W-1:0]  w_hold_inc;
  logic               w_hold_lim;
  logic               w_rel_norm;
  logic               w_rel_force;

  assign w_cand_p = i_req & w_eff_prio;
  assign w_cand_n = i_req & ~w_eff_prio;

  rr_pick #(.N(NUM_REQ), .IDW(ID_W)) u_pick_p (
    .i_cand  (w_cand_p),
    .i_start (r_ptr_p),
    .o_valid (w_vld_p),
    .o_idx   (w_idx_p)
  );

  rr_pick #(.N(NUM_REQ), .IDW(ID_W)) u_pick_n (
    .i_cand  (w_cand_n),
    .i_start (r_ptr_n),
    .o_valid (w_vld_n),
    .o_idx   (w_idx_n)
  );

  assign w_arb       = (r_state != SCHED_GRANT);
  assign w_win_vld   = w_vld_p | w_vld_n;
  assign w_win_idx   = w_vld_p ? w_idx_p : w_idx_n;
  assign w_ptr_nxt   = (w_win_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
  assign w_hold_inc  = r_hold + 1'b1;
  assign w_hold_lim  = (w_hold_inc == HOLD_W'(MAX_HOLD));
  // A dropped request from the owner counts as a voluntary release.
  assign w_rel_norm  = i_done | ~i_req[r_grant_id];
  assign w_rel_force = ~w_rel_norm & w_hold_lim;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= SCHED_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SCHED_IDLE, SCHED_RELEASE:
        w_state_nxt = w_win_vld ? SCHED_GRANT : SCHED_IDLE;
      SCHED_GRANT:
        if (w_rel_norm || w_hold_lim) w_state_nxt = SCHED_RELEASE;
      default:
        w_state_nxt = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant    <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_ptr_p    <= '0;
      r_ptr_n    <= '0;
      r_hold     <= '0;
    end else if (!w_arb) begin
      r_hold    <= w_hold_inc;
      r_timeout <= 1'b0;
      if (w_rel_norm || w_hold_lim) begin
        r_grant    <= '0;
        r_grant_id <= '0;
        r_busy     <= 1'b0;
        r_timeout  <= w_rel_force;
      end
    end else begin
      r_timeout <= 1'b0;
      if (w_win_vld) begin
        r_grant    <= NUM_REQ'(1) << w_win_idx;
        r_grant_id <= w_win_idx;
        r_busy     <= 1'b1;
        r_hold     <= '0;
        if (w_vld_p) r_ptr_p <= w_ptr_nxt;
        else         r_ptr_n <= w_ptr_nxt;
      end
    end
  end

`ifdef STARVATION_GUARD_EN
  logic [AGE_W-1:0] r_age [NUM_REQ];

  always_comb begin
    w_eff_prio = i_prio;
    for (int i = 0; i < NUM_REQ; i++)
      if (r_age[i] == AGE_W'(AGE_LIMIT)) w_eff_prio[i] = 1'b1;
  end

  // Losers age (saturating) on each arbitration; winners and idle requesters reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REQ; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!i_req[i]) begin
          r_age[i] <= '0;
        end else if (w_arb && w_win_vld) begin
          if (w_win_idx == ID_W'(i))                 r_age[i] <= '0;
          else if (r_age[i] != AGE_W'(AGE_LIMIT))    r_age[i] <= r_age[i] + 1'b1;
        end
      end
    end
  end
`else
  assign w_eff_prio = i_prio;
`endif

  assign o_grant    = r_grant;
  assign o_grant_id = r_grant_id;
  assign o_busy     = r_busy;
  assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_io_bus_scheduler.sv
// Self-checking bench for io_bus_scheduler: per-cycle reference model plus
// directed scenarios with literal grant expectations.
module tb_io_bus_scheduler;

  localparam int N     = 4;
  localparam int MAXH  = 4;
  localparam int AGEL  = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] prio;
  logic         done;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  io_bus_scheduler #(.NUM_REQ(N), .MAX_HOLD(MAXH), .AGE_LIMIT(AGEL)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_prio     (prio),
    .i_done     (done),
    .o_grant    (grant),
    .o_grant_id (grant_id),
    .o_busy     (busy),
    .o_timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = nobody), cycles held, pointers, ages.
  int m_owner = -1;
  int m_held  = 0;
  bit m_tmo   = 1'b0;
  int m_ptr_p = 0;
  int m_ptr_n = 0;
  int m_age [N];

  function automatic int first_from(input logic [N-1:0] c, input int p);
    for (int k = 0; k < N; k++)
      if (c[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] eff;
    int w;
    if (rst) begin
      m_owner = -1; m_held = 0; m_tmo = 1'b0; m_ptr_p = 0; m_ptr_n = 0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
    end else if (m_owner >= 0) begin
      m_held++;
      m_tmo = 1'b0;
      if (done || !req[m_owner]) m_owner = -1;
      else if (m_held == MAXH) begin m_owner = -1; m_tmo = 1'b1; end
    end else begin
      m_tmo = 1'b0;
      eff = prio;
`ifdef STARVATION_GUARD_EN
      for (int i = 0; i < N; i++) if (m_age[i] == AGEL) eff[i] = 1'b1;
`endif
      w = -1;
      if ((req & eff) != 0) begin
        w = first_from(req & eff, m_ptr_p); m_ptr_p = (w + 1) % N;
      end else if ((req & ~eff) != 0) begin
        w = first_from(req & ~eff, m_ptr_n); m_ptr_n = (w + 1) % N;
      end
      if (w >= 0) begin
        m_owner = w; m_held = 0;
`ifdef STARVATION_GUARD_EN
        for (int i = 0; i < N; i++)
          if (i == w) m_age[i] = 0;
          else if (req[i] && m_age[i] < AGEL) m_age[i]++;
`endif
      end
    end
    if (!rst) for (int i = 0; i < N; i++) if (!req[i]) m_age[i] = 0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_grant",   grant,    (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("m_grant_id", grant_id, (m_owner >= 0) ? m_owner : 0);
      check("m_busy",    busy,     m_owner >= 0);
      check("m_timeout", timeout,  m_tmo);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; prio = '0; done = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant();
    int n = 0;
    while (grant == '0 && n < 20) begin tick(); n++; end
  endtask

  task automatic serve(input logic [N-1:0] exp, input string nm);
    wait_grant();
    check(nm, grant, exp);
    done = 1'b1; tick(); done = 1'b0;
    check({nm, "_gap"}, grant, 0);
  endtask

  initial begin
    rst = 1'b1; req = '0; prio = '0; done = 1'b0;
    tick();
    chk_en = 1'b1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    tick();
    rst = 1'b0;

    // 1: two normal requesters alternate
    req = 4'b0101;
    serve(4'b0001, "t1_g0");
    serve(4'b0100, "t1_g1");
    serve(4'b0001, "t1_g2");
    req = '0;
    tick();

    // 2: priority requester first, normals in rotation
    do_reset();
    req = 4'b1111; prio = 4'b0100;
    serve(4'b0100, "t2_p");
    req = 4'b1011;
    serve(4'b0001, "t2_n0");
    req = 4'b1110;
    serve(4'b0100, "t2_p2");
    req = 4'b1010;
    serve(4'b0010, "t2_n1");
    req = 4'b1000;
    serve(4'b1000, "t2_n3");
    req = '0; prio = '0;
    tick();

    // 3: forced release after MAX_HOLD cycles
    do_reset();
    req = 4'b0010;
    wait_grant();
    for (int i = 0; i < MAXH; i++) begin
      check("t3_hold", grant, 4'b0010);
      check("t3_no_tmo", timeout, 0);
      tick();
    end
    check("t3_rel_grant", grant, 0);
    check("t3_tmo", timeout, 1);
    tick();
    check("t3_regrant", grant, 4'b0010);
    check("t3_tmo_clr", timeout, 0);

    // 4: done on the hold-limit edge is a normal release
    tick(); tick(); tick();
    check("t4_still", grant, 4'b0010);
    done = 1'b1; tick(); done = 1'b0;
    check("t4_rel", grant, 0);
    check("t4_no_tmo", timeout, 0);
    req = '0;
    tick();

    // 5: reset mid-grant clears outputs and pointers
    do_reset();
    req = 4'b0001;
    serve(4'b0001, "t5_pre");
    req = 4'b1000; prio = 4'b1000;
    wait_grant();
    check("t5_g3", grant, 4'b1000);
    tick();
    rst = 1'b1;
    tick();
    check("t5_grant", grant, 0);
    check("t5_busy", busy, 0);
    check("t5_id", grant_id, 0);
    tick();
    check("t5_hold_rst", grant, 0);
    req = 4'b0011; prio = '0; rst = 1'b0;
    tick();
    check("t5_ptr0", grant, 4'b0001);
    check("t5_ptr0_id", grant_id, 0);
    req = '0;
    tick(); tick();

    // 6: continuous priority traffic versus a waiting normal requester
    do_reset();
    req = 4'b1001; prio = 4'b1000;
    serve(4'b1000, "t6_a");
    serve(4'b1000, "t6_b");
    serve(4'b1000, "t6_c");
`ifdef STARVATION_GUARD_EN
    serve(4'b0001, "t6_promoted");
`else
    serve(4'b1000, "t6_starved");
`endif
    serve(4'b1000, "t6_e");
    req = '0; prio = '0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/io_bus_scheduler.md
# io_bus_scheduler

Arbitrates ownership of a single shared I/O resource between NUM_REQ requesters with two service classes. Priority-class requests always win over normal-class requests; within a class, grants rotate round-robin. Grants are held until the owner releases or a hold limit expires. It generalises the two-input priority/normal arbiter into a multi-requester scheduler sitting in front of the shared I/O port.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- MAX_HOLD, 16: maximum cycles one grant may be held, ≥1.
- AGE_LIMIT, 8: lost arbitrations before a normal request is promoted; used only with the macro.
- ID_W, clog2(NUM_REQ): width of grant_id (localparam).
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req  in  NUM_REQ  per-requester request level, held until served.
- prio  in  NUM_REQ  per-requester class, sampled with req (1 = priority).
- done  in  1  the current owner releases the resource; ignored when no grant is active.
- grant  out  NUM_REQ  one-hot ownership, or all zero.
- grant_id  out  ID_W  index of the owner; 0 when grant is zero.
- busy  out  1  high while grant is nonzero.
- timeout  out  1  one-cycle pulse on a forced release.

## Operation
- **States:**
  - IDLE: no grant.
  - GRANT: grant held.
  - RELEASE: one cycle with grant = 0; arbitrates exactly like IDLE.
- **Arbitration** (in IDLE or RELEASE, at each edge):
  - cand_p = req & effective_prio; cand_n = req & ~effective_prio.
  - If cand_p ≠ 0, pick from cand_p starting at ptr_p and wrapping; else pick from cand_n starting at ptr_n.
  - The winner i is registered into grant/grant_id and the state moves to GRANT.
  - The pointer of the winning class becomes (i+1) mod NUM_REQ.
  - If req = 0, IDLE stays IDLE and RELEASE moves to IDLE.
- **Release.** In GRANT, the grant ends on whichever comes first:
  - done = 1;
  - req[owner] = 0, treated as done;
  - hold count reaching MAX_HOLD, a forced release that asserts timeout.
  
  Any release → RELEASE.
- **Hold counter:** width clog2(MAX_HOLD+1); cleared on entry to GRANT; +1 each GRANT cycle.
- **Simultaneous events:**
  - done on the same edge as the hold limit: treated as a normal release, timeout stays 0.
  - Requests changing during GRANT: no effect until the next arbitration.
- **Reset, at any time including mid-grant:**
  - state = IDLE; grant = 0, grant_id = 0, busy = 0, timeout = 0;
  - ptr_p = ptr_n = 0; hold count = 0; all ages = 0.

## Timing
- **Grant latency:** req seen at edge k in IDLE → grant high after edge k (1 cycle).
- **Grant duration:** grant covers 1..MAX_HOLD cycles.
- **Release, done sampled at edge t:**
  - grant low during cycle t..t+1 (RELEASE);
  - the next grant rises at edge t+1;
  - this gives a 1-cycle gap between owners.
- **Forced release:** the owner holds for exactly MAX_HOLD cycles; timeout is high during the RELEASE cycle only.
- **Outputs:** all outputs are registered; none are combinational from inputs.

## Configuration
- **Macro:** STARVATION_GUARD_EN.
- **Defined:**
  - Each requester has an age counter of width clog2(AGE_LIMIT+1).
  - At each arbitration, the counter increments (saturating) for every requester with req = 1 that is not the winner.
  - It clears when that requester is granted or its req = 0.
  - effective_prio[i] = prio[i] | (age[i] == AGE_LIMIT).
  - A promoted requester updates ptr_p when it wins.
- **Undefined:**
  - effective_prio = prio and no age logic exists.
  - Normal requesters may starve under continuous priority traffic.

## Structure
- **Shared definitions include:**
  - state encodings SCHED_IDLE, SCHED_GRANT, SCHED_RELEASE;
  - the clog2 constant function.
- **Sub-module rr_pick:**
  - combinational: takes a candidate vector and a start pointer; returns a valid flag and the winning index;
  - instantiated twice (priority class and normal class).

## Test plan
Bench settings: NUM_REQ=4, MAX_HOLD=4, AGE_LIMIT=3.

1. req=0101, prio=0000, done pulsed 1 cycle after each grant → grant sequence 0001, 0100, 0001, with a 1-cycle zero gap between grants.
2. req=1111, prio=0100 → grant 0100 first; after done, the remaining normal requesters are served in order 0001, 0010, 1000, with the priority requester re-winning whenever it is requesting.
3. req=0010, done never asserted → grant 0010 held exactly 4 cycles; timeout=1 for the following cycle; grant reasserted after the 1-cycle gap.
4. done and hold limit on the same edge → release occurs, timeout=0.
5. Reset asserted mid-grant (grant=1000) → after that edge: grant=0, busy=0, grant_id=0; the next arbitration starts at index 0.
6. With STARVATION_GUARD_EN: req=1001, prio=1000, the priority requester re-requests continuously → requester 0 is granted after 3 lost arbitrations. Without the macro, requester 0 is never granted.
